// File: rtl/hazard_stall_unit.sv
// RAW interlock for a 5-stage pipeline without forwarding: shadow scoreboard of
// in-flight destinations in EX/MEM/WB, stall/bubble control and saturating perf counters.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dst,
    input  logic             flush,
    output logic             stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] r;
    } sb_entry_t;

    sb_entry_t sb_ex, sb_mem, sb_wb;
    logic      hazard;
    logic      rs_hit, rt_hit;

    function automatic logic hit(input sb_entry_t e, input logic [4:0] r);
        return e.v && (e.r == r) && (r != 5'd0);
    endfunction

    always_comb begin
        rs_hit = hit(sb_ex, id_rs) || hit(sb_mem, id_rs) || hit(sb_wb, id_rs);
        rt_hit = hit(sb_ex, id_rt) || hit(sb_mem, id_rt) || hit(sb_wb, id_rt);
        hazard = id_valid && ((id_use_rs && rs_hit) || (id_use_rt && rt_hit));
    end

    assign stall       = hazard;
    assign pc_en       = ~hazard;
    assign ifid_en     = ~hazard;
    assign idex_bubble = hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (flush) begin
                sb_ex  <= '0;
                sb_mem <= '0;
                sb_wb  <= '0;
            end else begin
                sb_wb    <= sb_mem;
                sb_mem   <= sb_ex;
                // a stalled instruction enters as an invalid entry: the bubble
                sb_ex.v  <= id_valid && !hazard && id_reg_write && (id_dst != 5'd0);
                sb_ex.r  <= id_dst;
            end
            if (hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (id_valid && !hazard && (issue_cnt != '1))
                issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

endmodule
